// File: rtl/ethernet_rx_burst.sv
// rtl/ethernet_rx_burst.sv - RMII receiver decoding burst request frames into a FWFT request FIFO
module ethernet_rx_burst #(
  parameter logic [47:0] FPGA_MAC    = 48'h0,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          ADDR_WIDTH  = 16,
  parameter int          DATA_WIDTH  = 16,
  parameter int          MAX_RECORDS = 8,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  crsdv,
  input  logic [1:0]            rxd,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [15:0]           frames_ok,
  output logic [15:0]           rec_drop,
  output logic                  frame_err
);
  localparam int REC_BYTES = 1 + ADDR_WIDTH / 8 + DATA_WIDTH / 8;
  localparam int REC_W     = 8 * REC_BYTES;
  localparam int ACC_W     = (REC_W > 48) ? REC_W : 48;
  localparam int ENTRY_W   = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]       REC_LAST = 4'(REC_BYTES - 1);
  localparam logic [7:0]       MAX_REC  = 8'(MAX_RECORDS);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_DST, S_SRC, S_ETYPE, S_COUNT, S_REC, S_DROP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           dibit_q, dibit_d;
  logic [5:0]           shift_q, shift_d;
  logic [3:0]           byte_cnt_q, byte_cnt_d;
  logic [ACC_W-9:0]     acc_q, acc_d;
  logic [7:0]           rec_left_q, rec_left_d;
  logic [ENTRY_W-1:0]   entry_q, entry_d;
  logic                 op_ok_q, op_ok_d;
  logic                 commit_q, commit_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;
  logic                 armed_q, armed_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [15:0]          frames_ok_q, frames_ok_d, rec_drop_q, rec_drop_d;
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];

  logic                 in_frame, byte_done, pop, room, push;
  logic [7:0]           byte_val;
  logic [ACC_W-1:0]     acc_next;
  logic [ENTRY_W-1:0]   head;

  assign in_frame  = (state_q == S_DST) || (state_q == S_SRC) || (state_q == S_ETYPE) ||
                     (state_q == S_COUNT) || (state_q == S_REC);
  assign byte_done = crsdv && (dibit_q == 2'd3) && in_frame;
  assign byte_val  = {rxd, shift_q};
  assign acc_next  = {acc_q, byte_val};

  always_comb begin
    state_d    = state_q;
    dibit_d    = crsdv ? dibit_q + 2'd1 : 2'd0;
    shift_d    = {rxd, shift_q[5:2]};
    byte_cnt_d = byte_cnt_q;
    acc_d      = acc_q;
    rec_left_d = rec_left_q;
    entry_d    = entry_q;
    op_ok_d    = op_ok_q;
    commit_d   = 1'b0;
    last_d     = 1'b0;
    err_d      = 1'b0;
    armed_d    = armed_q | ~crsdv;
    if (byte_done) begin
      acc_d      = acc_next[ACC_W-9:0];
      byte_cnt_d = byte_cnt_q + 4'd1;
    end
    case (state_q)
      S_IDLE: begin
        dibit_d = 2'd0;
        if (crsdv && rxd == 2'b01 && armed_q) state_d = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        dibit_d    = 2'd0;
        byte_cnt_d = 4'd0;
        if (crsdv && rxd == 2'b11) state_d = S_DST;
      end
      S_DST: if (byte_done && byte_cnt_q == 4'd5) begin
        byte_cnt_d = 4'd0;
        state_d    = (acc_next[47:0] == FPGA_MAC) ? S_SRC : S_DROP;
      end
      S_SRC: if (byte_done && byte_cnt_q == 4'd5) begin
        byte_cnt_d = 4'd0;
        state_d    = S_ETYPE;
      end
      S_ETYPE: if (byte_done && byte_cnt_q == 4'd1) begin
        byte_cnt_d = 4'd0;
        state_d    = (acc_next[15:0] == ETHERTYPE) ? S_COUNT : S_DROP;
      end
      S_COUNT: if (byte_done) begin
        byte_cnt_d = 4'd0;
        rec_left_d = byte_val;
        state_d    = (byte_val != 8'd0 && byte_val <= MAX_REC) ? S_REC : S_DROP;
      end
      S_REC: if (byte_done && byte_cnt_q == REC_LAST) begin
        // Record is latched here and pushed one cycle later.
        byte_cnt_d = 4'd0;
        commit_d   = 1'b1;
        last_d     = (rec_left_q == 8'd1);
        op_ok_d    = (acc_next[REC_W-1 -: 7] == 7'd0);
        entry_d    = {acc_next[REC_W-8], acc_next[ADDR_WIDTH+DATA_WIDTH-1:0]};
        rec_left_d = rec_left_q - 8'd1;
        if (rec_left_q == 8'd1) state_d = S_DROP;
      end
      S_DROP: ;
      default: state_d = S_IDLE;
    endcase
    if (!crsdv && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = in_frame && (state_q != S_DST);
    end
  end

  assign pop  = valid_o && ready_i;
  assign room = (count_q != DEPTH_C) || pop;
  assign push = commit_q && op_ok_q && room;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    frames_ok_d = frames_ok_q;
    rec_drop_d  = rec_drop_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) count_d = count_q + (PTR_W + 1)'(1);
    if (pop && !push) count_d = count_q - (PTR_W + 1)'(1);
    if (commit_q && last_q) frames_ok_d = frames_ok_q + 16'd1;
    if (commit_q && (!op_ok_q || !room)) rec_drop_d = rec_drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dibit_q     <= 2'd0;
      shift_q     <= 6'd0;
      byte_cnt_q  <= 4'd0;
      acc_q       <= '0;
      rec_left_q  <= 8'd0;
      entry_q     <= '0;
      op_ok_q     <= 1'b0;
      commit_q    <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      frames_ok_q <= 16'd0;
      rec_drop_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      dibit_q     <= dibit_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      acc_q       <= acc_d;
      rec_left_q  <= rec_left_d;
      entry_q     <= entry_d;
      op_ok_q     <= op_ok_d;
      commit_q    <= commit_d;
      last_q      <= last_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frames_ok_q <= frames_ok_d;
      rec_drop_q  <= rec_drop_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_q;
  end

  assign head      = mem_q[rd_ptr_q];
  assign valid_o   = (count_q != '0);
  assign rw_o      = valid_o ? head[ENTRY_W-1] : 1'b0;
  assign addr_o    = valid_o ? head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign data_o    = valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign frames_ok = frames_ok_q;
  assign rec_drop  = rec_drop_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_ethernet_rx_burst.sv
// tb/tb_ethernet_rx_burst.sv - directed and randomized frame bench with a queue-based request model
module tb_ethernet_rx_burst;
  localparam int MAXR  = 32;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, crsdv, ready_i;
  logic [1:0]  rxd;
  logic [15:0] addr_o, data_o, frames_ok, rec_drop;
  logic        rw_o, valid_o, frame_err;

  ethernet_rx_burst #(
    .FPGA_MAC(48'h0), .ETHERTYPE(16'h88B5), .ADDR_WIDTH(16), .DATA_WIDTH(16),
    .MAX_RECORDS(MAXR), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o), .ready_i(ready_i),
    .frames_ok(frames_ok), .rec_drop(rec_drop), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          err_seen = 0;
  int          m_err = 0;
  int          beats = 0;
  int          b0;
  bit          lat_chk = 1'b0;
  logic [15:0] m_frames = 16'd0;
  logic [15:0] m_drop = 16'd0;
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;
  logic [7:0]  frm [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted beat must be the oldest outstanding model request.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_seen++;
    if (valid_o === 1'b1 && ready_i === 1'b1 && rst === 1'b0) begin
      beats++;
      if (exp_q.size() == 0) chk("extra_beat", 64'(exp_q.size()), 64'd1);
      else begin
        mon_e = exp_q.pop_front();
        if (mon_e[32]) chk("beat_wr", 64'({rw_o, addr_o, data_o}), 64'(mon_e));
        else           chk("beat_rd", 64'({rw_o, addr_o}), 64'(mon_e[32:16]));
      end
    end
  end

  task automatic send_dibit(input logic [1:0] d);
    crsdv = 1'b1;
    rxd   = d;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_dibit(b[2*i +: 2]);
  endtask

  task automatic idle(input int n);
    crsdv = 1'b0;
    rxd   = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [47:0] dst, input logic [15:0] et, input logic [7:0] cnt);
    frm.delete();
    for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    frm.push_back(cnt);
  endtask

  task automatic rec(input logic [7:0] op, input logic [15:0] a, input logic [15:0] d);
    frm.push_back(op);
    frm.push_back(a[15:8]);
    frm.push_back(a[7:0]);
    frm.push_back(d[15:8]);
    frm.push_back(d[7:0]);
  endtask

  task automatic tail();
    repeat (4 + $urandom_range(0, 3)) frm.push_back(8'($urandom));
  endtask

  task automatic send_frame(input int trunc, input bit raise_ready, input bit rst_mid);
    bit          ok_dst, ok_et, ok_cnt;
    int          cnt, nd, k, r;
    logic [7:0]  b, op;
    logic [32:0] e;
    ok_dst = 1'b1;
    for (int i = 0; i < 6; i++) if (frm[i] != 8'h00) ok_dst = 1'b0;
    ok_et  = ({frm[12], frm[13]} == 16'h88B5);
    cnt    = int'(frm[14]);
    ok_cnt = (cnt >= 1) && (cnt <= MAXR);
    for (int i = 0; i < 7; i++) send_byte(8'h55);
    send_byte(8'hD5);
    nd = (trunc < 0) ? frm.size() * 4 : trunc;
    for (int dd = 0; dd < nd; dd++) begin
      b = frm[dd / 4];
      send_dibit(b[2*(dd % 4) +: 2]);
      k = dd / 4 + 1;
      r = (k - 15) / 5;
      if (dd % 4 == 3 && ok_dst && ok_et && ok_cnt && k >= 20 && (k - 15) % 5 == 0 && r <= cnt) begin
        if (raise_ready && r == cnt) ready_i = 1'b1;
        op = frm[k - 5];
        e  = {op[0], frm[k - 4], frm[k - 3], frm[k - 2], frm[k - 1]};
        if (op > 8'd1) m_drop++;
        else if (ready_i || exp_q.size() < DEPTH) exp_q.push_back(e);
        else m_drop++;
        if (r == cnt) begin
          m_frames++;
          if (lat_chk) begin
            chk("lat_valid_t1", 64'(valid_o), 64'd0);
            @(posedge clk); #1;
            chk("lat_valid_t2", 64'(valid_o), 64'd1);
            chk("lat_head", 64'({rw_o, addr_o, data_o}), 64'(e));
          end
        end
      end
    end
    k = nd / 4;
    if (rst_mid) begin
      rst = 1'b1;
      send_dibit(2'b01);
      rst = 1'b0;
      exp_q.delete();
      m_frames = 16'd0;
      m_drop   = 16'd0;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_frames_ok", 64'(frames_ok), 64'(m_frames));
      chk("rst_rec_drop", 64'(rec_drop), 64'(m_drop));
      ready_i = 1'b1;
      repeat (8) send_dibit(2'b01);
      send_dibit(2'b11);
      foreach (frm[i]) send_byte(frm[i]);
    end else if (nd < frm.size() * 4 && ok_dst && k >= 6 &&
                 (k < 14 || (ok_et && (k == 14 || (ok_cnt && k < 15 + 5 * cnt))))) begin
      m_err++;
    end
    idle(10);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    idle(2);
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frames_ok"}, 64'(frames_ok), 64'(m_frames));
    chk({tag, "_rec_drop"}, 64'(rec_drop), 64'(m_drop));
    chk({tag, "_frame_err"}, 64'(err_seen), 64'(m_err));
  endtask

  initial begin
    rst = 1'b1; crsdv = 1'b0; rxd = 2'b00; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_outputs", 64'({rw_o, addr_o, data_o}), 64'd0);
    chk("reset_frames_ok", 64'(frames_ok), 64'd0);
    chk("reset_rec_drop", 64'(rec_drop), 64'd0);
    chk("reset_frame_err", 64'(frame_err), 64'd0);
    rst = 1'b0;
    idle(2);

    hdr(48'h0, 16'h88B5, 8'd1); rec(8'h01, 16'h1234, 16'hBEEF); tail();
    lat_chk = 1'b1; send_frame(-1, 1'b0, 1'b0); lat_chk = 1'b0;
    drain(); check_counters("single");

    hdr(48'h0, 16'h88B5, 8'd3);
    rec(8'h00, 16'h0001, 16'($urandom)); rec(8'h01, 16'h0002, 16'h00AA); rec(8'h00, 16'h0003, 16'($urandom));
    tail(); send_frame(-1, 1'b0, 1'b0); drain(); check_counters("three");

    hdr(48'h0000_0000_0A01, 16'h88B5, 8'd1); rec(8'h01, 16'h5555, 16'h6666); tail();
    send_frame(-1, 1'b0, 1'b0); drain(); check_counters("bad_dst");
    hdr(48'h0, 16'h0800, 8'd1); rec(8'h01, 16'h5555, 16'h6666); tail();
    send_frame(-1, 1'b0, 1'b0); drain(); check_counters("bad_etype");
    hdr(48'h0, 16'h88B5, 8'd0); rec(8'h01, 16'h7777, 16'h8888); tail();
    send_frame(-1, 1'b0, 1'b0); drain(); check_counters("count_zero");
    hdr(48'h0, 16'h88B5, 8'(MAXR + 1)); rec(8'h01, 16'h7777, 16'h8888); tail();
    send_frame(-1, 1'b0, 1'b0); drain(); check_counters("count_over");
    hdr(48'h0, 16'h88B5, 8'(MAXR));
    for (int i = 0; i < MAXR; i++) rec(8'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    tail(); send_frame(-1, 1'b0, 1'b0); drain(); check_counters("count_max");

    ready_i = 1'b0;
    b0 = beats;
    hdr(48'h0, 16'h88B5, 8'd20);
    for (int i = 0; i < 20; i++) rec(8'h01, 16'(16'h0100 + i), 16'($urandom));
    tail(); send_frame(-1, 1'b0, 1'b0);
    chk("full_valid", 64'(valid_o), 64'd1);
    chk("full_head", 64'({rw_o, addr_o, data_o}), 64'(exp_q[0]));
    idle(3);
    chk("full_head_hold", 64'({rw_o, addr_o, data_o}), 64'(exp_q[0]));
    check_counters("full");
    hdr(48'h0, 16'h88B5, 8'd1); rec(8'h01, 16'hF00D, 16'h1357); tail();
    send_frame(-1, 1'b1, 1'b0);
    drain();
    chk("full_drain_beats", 64'(beats - b0), 64'd17);
    check_counters("full_pushpop");

    hdr(48'h0, 16'h88B5, 8'd3);
    for (int i = 0; i < 3; i++) rec(8'h01, 16'($urandom), 16'($urandom));
    tail(); send_frame(15 * 4 + 5 * 4 + 6, 1'b0, 1'b0); drain(); check_counters("trunc");

    hdr(48'h0, 16'h88B5, 8'd3);
    rec(8'h01, 16'h0A0A, 16'h1111); rec(8'h07, 16'h0B0B, 16'h2222); rec(8'h00, 16'h0C0C, 16'h3333);
    tail(); send_frame(-1, 1'b0, 1'b0); drain(); check_counters("bad_op");

    for (int f = 0; f < 12; f++) begin
      int n;
      int tr;
      n = $urandom_range(1, 6);
      hdr(($urandom_range(0, 7) == 0) ? 48'h0000_0000_0A01 : 48'h0,
          ($urandom_range(0, 7) == 0) ? 16'h0800 : 16'h88B5, 8'(n));
      for (int i = 0; i < n; i++)
        rec(($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom));
      tail();
      tr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, frm.size() * 4 - 1)) : -1;
      send_frame(tr, 1'b0, 1'b0);
      drain();
      check_counters("rand");
    end

    ready_i = 1'b0;
    hdr(48'h0, 16'h88B5, 8'd3);
    for (int i = 0; i < 3; i++) rec(8'h01, 16'($urandom), 16'($urandom));
    tail(); send_frame(15 * 4 + 10 * 4 + 5, 1'b0, 1'b1); drain(); check_counters("rst_mid");

    hdr(48'h0, 16'h88B5, 8'd2);
    rec(8'h01, 16'h4242, 16'h9999); rec(8'h00, 16'h4343, 16'h0000);
    tail(); send_frame(-1, 1'b0, 1'b0); drain(); check_counters("recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
